// File: rtl/switch_irq_servicer.sv
// Services switch PIO interrupts: read/clear edge_capture, read levels, queue {edges,levels} events.
// Optional SWITCH_SVC_INIT_EN adds a one-shot irq_mask write after every reset.
module switch_irq_servicer #(
  parameter logic [1:0]  IRQ_MASK   = 2'b11,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pio_irq,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  input  logic [31:0] pio_readdata,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [3:0]  ev_data,
  output logic [4:0]  ev_count
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned EV_W   = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
`ifdef SWITCH_SVC_INIT_EN
    S_INIT     = 3'd7,
`endif
    S_IDLE     = 3'd0,
    S_EC_ADDR  = 3'd1,
    S_EC_CAP   = 3'd2,
    S_EC_CLR   = 3'd3,
    S_DAT_ADDR = 3'd4,
    S_DAT_CAP  = 3'd5,
    S_PUSH     = 3'd6
  } state_t;

`ifdef SWITCH_SVC_INIT_EN
  localparam state_t RESET_STATE = S_INIT;
`else
  localparam state_t RESET_STATE = S_IDLE;
  logic [1:0] w_unused_mask;
  assign w_unused_mask = IRQ_MASK;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_edges;
  logic [1:0]        r_levels;
  logic [EV_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [29:0]       w_unused_rd;

  assign w_unused_rd = pio_readdata[31:2];
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push      = (r_state == S_PUSH);
  assign w_pop       = (r_count != '0) && ev_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= RESET_STATE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
`ifdef SWITCH_SVC_INIT_EN
      S_INIT:     w_state_nxt = S_IDLE;
`endif
      S_IDLE:     if (pio_irq && !w_full) w_state_nxt = S_EC_ADDR;
      S_EC_ADDR:  w_state_nxt = S_EC_CAP;
      // Nothing latched means a spurious interrupt: skip the clear and the push.
      S_EC_CAP:   w_state_nxt = (pio_readdata[1:0] == 2'b00) ? S_IDLE : S_EC_CLR;
      S_EC_CLR:   w_state_nxt = S_DAT_ADDR;
      S_DAT_ADDR: w_state_nxt = S_DAT_CAP;
      S_DAT_CAP:  w_state_nxt = S_PUSH;
      S_PUSH:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // PIO bus decode; reset forces the idle bus so an interrupted write never lands.
  always_comb begin
    pio_address    = 2'd0;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_writedata  = '0;
    if (!reset) begin
      case (r_state)
`ifdef SWITCH_SVC_INIT_EN
        S_INIT: begin
          pio_address    = 2'd2;
          pio_chipselect = 1'b1;
          pio_write_n    = 1'b0;
          pio_writedata  = DATA_W'(IRQ_MASK);
        end
`endif
        S_EC_ADDR, S_EC_CAP: begin
          pio_address    = 2'd3;
          pio_chipselect = 1'b1;
        end
        S_EC_CLR: begin
          pio_address    = 2'd3;
          pio_chipselect = 1'b1;
          pio_write_n    = 1'b0;
          pio_writedata  = DATA_W'(r_edges);
        end
        S_DAT_ADDR, S_DAT_CAP: begin
          pio_address    = 2'd0;
          pio_chipselect = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_edges  <= 2'b00;
      r_levels <= 2'b00;
    end else begin
      if (r_state == S_EC_CAP)  r_edges  <= pio_readdata[1:0];
      if (r_state == S_DAT_CAP) r_levels <= pio_readdata[1:0];
    end
  end

  // First-word-fall-through event queue; pointers wrap on their natural width.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_edges, r_levels};
  end

  assign ev_valid = (r_count != '0);
  assign ev_data  = r_mem[r_rd_ptr];
  assign ev_count = r_count;

endmodule

// File: tb/tb_switch_irq_servicer.sv
// Directed bench for switch_irq_servicer with a behavioural switch PIO (edge capture, bit-clear).
module tb_switch_irq_servicer;

`ifdef SWITCH_SVC_INIT_EN
  localparam logic [1:0] MASK_INIT = 2'b00;
`else
  localparam logic [1:0] MASK_INIT = 2'b11;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pio_irq;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [3:0]  ev_data;
  logic [4:0]  ev_count;

  switch_irq_servicer #(.IRQ_MASK(2'b11), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .pio_irq(pio_irq),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_data(ev_data), .ev_count(ev_count)
  );

  always #5 clk = ~clk;

  // PIO model
  logic [1:0]  m_sw = 2'b00;
  logic [1:0]  m_sw_d = 2'b00;
  logic [1:0]  m_ec = 2'b00;
  logic [1:0]  m_mask = MASK_INIT;
  logic        m_force = 1'b0;
  logic [31:0] m_rd = '0;
  logic [1:0]  m_clr;
  int          n_wr = 0, n_wr3 = 0, n_rd0 = 0, n_rd3 = 0;
  logic [31:0] wlog[$];

  assign pio_irq      = (|(m_ec & m_mask)) | m_force;
  assign pio_readdata = m_rd;
  assign m_clr = (pio_chipselect && !pio_write_n && pio_address == 2'd3) ? pio_writedata[1:0] : 2'b00;

  always @(posedge clk) begin
    if (pio_chipselect && !pio_write_n) begin
      n_wr <= n_wr + 1;
      if (pio_address == 2'd2) m_mask <= pio_writedata[1:0];
      if (pio_address == 2'd3) begin
        n_wr3 <= n_wr3 + 1;
        wlog.push_back(pio_writedata);
      end
    end
    if (pio_chipselect && pio_write_n) begin
      if (pio_address == 2'd0) n_rd0 <= n_rd0 + 1;
      if (pio_address == 2'd3) n_rd3 <= n_rd3 + 1;
    end
    if (pio_chipselect) begin
      case (pio_address)
        2'd0:    m_rd <= {30'd0, m_sw};
        2'd2:    m_rd <= {30'd0, m_mask};
        2'd3:    m_rd <= {30'd0, m_ec};
        default: m_rd <= '0;
      endcase
    end
    m_ec   <= (m_ec & ~m_clr) | (m_sw & ~m_sw_d);
    m_sw_d <= m_sw;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One rising edge on the given switches, then release them; allow time for service.
  task automatic gen_event(input logic [1:0] bits);
    m_sw = bits;
    @(negedge clk);
    m_sw = 2'b00;
    wait_neg(12);
  endtask

  task automatic pop_check(input string tag, input logic [3:0] exp);
    check_eq({tag, "_valid"}, 32'(ev_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(ev_data), 32'(exp));
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  int base_wr, base_wr3, base_rd0, base_rd3, base_log, lat;

  initial begin
    // Test 1: reset and release
    wait_neg(3);
    check_eq("rst_cs", 32'(pio_chipselect), 32'd0);
    check_eq("rst_wn", 32'(pio_write_n), 32'd1);
    check_eq("rst_valid", 32'(ev_valid), 32'd0);
    check_eq("rst_count", 32'(ev_count), 32'd0);
    reset = 1'b0;
    #1;
`ifdef SWITCH_SVC_INIT_EN
    check_eq("init_addr", 32'(pio_address), 32'd2);
    check_eq("init_cs", 32'(pio_chipselect), 32'd1);
    check_eq("init_wn", 32'(pio_write_n), 32'd0);
    check_eq("init_wd", pio_writedata, 32'h3);
    @(negedge clk);
    check_eq("init_nwr", 32'(n_wr), 32'd1);
    check_eq("init_mask", 32'(m_mask), 32'd3);
`else
    check_eq("noinit_cs", 32'(pio_chipselect), 32'd0);
    @(negedge clk);
    check_eq("noinit_nwr", 32'(n_wr), 32'd0);
`endif
    check_eq("idle_cs", 32'(pio_chipselect), 32'd0);
    wait_neg(2);

    // Test 2: switch 0 rising edge, latency and bus sequence
    base_wr3 = n_wr3; base_rd0 = n_rd0; base_rd3 = n_rd3; base_log = wlog.size();
    m_sw = 2'b01;
    @(posedge clk);
    @(negedge clk);
    check_eq("t2_irq", 32'(pio_irq), 32'd1);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!ev_valid && lat < 20);
    check_eq("t2_latency", 32'(lat), 32'd7);
    check_eq("t2_data", 32'(ev_data), 32'h5);
    check_eq("t2_nwr3", 32'(n_wr3 - base_wr3), 32'd1);
    check_eq("t2_wdata", wlog[base_log], 32'h1);
    check_eq("t2_rd3", 32'(n_rd3 - base_rd3), 32'd2);
    check_eq("t2_rd0", 32'(n_rd0 - base_rd0), 32'd2);
    check_eq("t2_irq_clr", 32'(pio_irq), 32'd0);
    pop_check("t2_pop", 4'b0101);
    check_eq("t2_empty", 32'(ev_count), 32'd0);
    m_sw = 2'b00;
    wait_neg(2);

    // Test 3: spurious interrupt
    base_wr = n_wr; base_rd0 = n_rd0; base_rd3 = n_rd3;
    m_force = 1'b1;
    @(negedge clk);
    m_force = 1'b0;
    wait_neg(6);
    check_eq("t3_nwr", 32'(n_wr - base_wr), 32'd0);
    check_eq("t3_rd3", 32'(n_rd3 - base_rd3), 32'd2);
    check_eq("t3_rd0", 32'(n_rd0 - base_rd0), 32'd0);
    check_eq("t3_count", 32'(ev_count), 32'd0);

    // Test 4: fill, stall while full, resume after one pop
    gen_event(2'b01);
    gen_event(2'b10);
    gen_event(2'b01);
    gen_event(2'b10);
    check_eq("t4_full", 32'(ev_count), 32'd4);
    base_wr3 = n_wr3;
    gen_event(2'b11);
    check_eq("t4_stall_count", 32'(ev_count), 32'd4);
    check_eq("t4_stall_irq", 32'(pio_irq), 32'd1);
    check_eq("t4_stall_nwr", 32'(n_wr3 - base_wr3), 32'd0);
    pop_check("t4_pop0", 4'b0100);
    check_eq("t4_after_pop", 32'(ev_count), 32'd3);
    wait_neg(12);
    check_eq("t4_refill", 32'(ev_count), 32'd4);
    check_eq("t4_irq_done", 32'(pio_irq), 32'd0);
    pop_check("t4_pop1", 4'b1000);
    pop_check("t4_pop2", 4'b0100);
    pop_check("t4_pop3", 4'b1000);
    pop_check("t4_pop4", 4'b1100);
    check_eq("t4_drained", 32'(ev_valid), 32'd0);

    // Test 5: switches toggle while edge_capture is being read
    base_wr3 = n_wr3; base_log = wlog.size();
    m_sw = 2'b01;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    m_sw = 2'b10;
    wait_neg(25);
    check_eq("t5_nwr3", 32'(n_wr3 - base_wr3), 32'd2);
    check_eq("t5_wdata0", wlog[base_log], 32'h1);
    check_eq("t5_wdata1", wlog[base_log + 1], 32'h2);
    check_eq("t5_count", 32'(ev_count), 32'd2);
    pop_check("t5_pop0", 4'b0110);
    pop_check("t5_pop1", 4'b1010);
    m_sw = 2'b00;
    wait_neg(3);

    // Test 6: reset while the clear write is on the bus
    gen_event(2'b01);
    gen_event(2'b10);
    check_eq("t6_queued", 32'(ev_count), 32'd2);
    base_wr3 = n_wr3;
    m_sw = 2'b01;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("t6_cs_gated", 32'(pio_chipselect), 32'd0);
    wait_neg(2);
    check_eq("t6_nwr3", 32'(n_wr3 - base_wr3), 32'd0);
    check_eq("t6_count", 32'(ev_count), 32'd0);
    check_eq("t6_valid", 32'(ev_valid), 32'd0);
    reset = 1'b0;
    wait_neg(15);
    check_eq("t6_reservice", 32'(ev_count), 32'd1);
    check_eq("t6_data", 32'(ev_data), 32'h5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
